acq_scheduler: RTL and testbench

Acquisition scheduler in the 100 MHz system domain, between the USB command path and the A/D capture wrapper. It decodes host commands into the capture configuration and sequences each shot. For each shot it issues the start strobe, waits for the capture wrapper to acknowledge and finish, and waits for its read FIFO to drain. Shots repeat at a programmable pulse-repetition period and raise flags for overrun and acknowledge timeout.

---
 rtl/acq_scheduler_if.sv | 21 ++
 rtl/acq_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_acq_scheduler.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/acq_scheduler_if.sv
// Handshake between the acquisition scheduler and the A/D capture wrapper.
interface acq_scheduler_if;
  logic        o_st;
  logic [15:0] o_recv_count;
  logic        i_working;
  logic        i_rd_empty;

  modport master (
    output o_st,
    output o_recv_count,
    input  i_working,
    input  i_rd_empty
  );

  modport slave (
    input  o_st,
    input  o_recv_count,
    output i_working,
    output i_rd_empty
  );
endinterface

// File: rtl/acq_scheduler.sv
// Acquisition scheduler: decodes host commands into capture configuration and
// sequences each shot (strobe, acknowledge, capture, FIFO drain, repetition wait).
module acq_scheduler #(
  parameter int unsigned MIN_RECV    = 16,
  parameter int unsigned DEF_RECV    = 10000,
  parameter int unsigned DEF_PERIOD  = 100000,
  parameter int unsigned MIN_PERIOD  = 64,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic            i_clk_sys,
  input  logic            i_rst_n,
  input  logic            i_cmd_come,
  input  logic [7:0]      i_cmd,
  input  logic [31:0]     i_cmd_param,
  acq_scheduler_if.master cap,
  output logic            o_busy,
  output logic [15:0]     o_shot_count,
  output logic            o_overrun,
  output logic            o_timeout,
  output logic [3:0]      o_led
);

  localparam logic [15:0] MIN_RECV_W    = 16'(MIN_RECV);
  localparam logic [15:0] DEF_RECV_W    = 16'(DEF_RECV);
  localparam logic [31:0] DEF_PERIOD_W  = 32'(DEF_PERIOD);
  localparam logic [31:0] MIN_PERIOD_W  = 32'(MIN_PERIOD);
  localparam logic [31:0] ACK_TIMEOUT_W = 32'(ACK_TIMEOUT);

  localparam logic [7:0] CMD_SET_RECV   = 8'h01;
  localparam logic [7:0] CMD_SET_PERIOD = 8'h02;
  localparam logic [7:0] CMD_START      = 8'h03;
  localparam logic [7:0] CMD_STOP       = 8'h04;
  localparam logic [7:0] CMD_SINGLE     = 8'h05;
  localparam logic [7:0] CMD_LED        = 8'h06;
  localparam logic [7:0] CMD_CLEAR      = 8'h07;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRE,
    S_ACK,
    S_CAPTURE,
    S_DRAIN,
    S_WAIT
  } state_e;

  state_e      state_q, state_d;
  logic        run_q, run_d;
  logic        single_q, single_d;
  logic [31:0] period_q, period_d;
  logic [31:0] cnt_q, cnt_d;
  logic [15:0] recv_shadow_q, recv_shadow_d;
  logic [15:0] recv_count_q, recv_count_d;
  logic [15:0] shot_count_q, shot_count_d;
  logic        overrun_q, overrun_d;
  logic        timeout_q, timeout_d;
  logic [3:0]  led_q, led_d;
  logic        st_q, st_d;
  logic        busy_q, busy_d;
  logic        fire_due;
  logic        in_shot;

  // Next-state logic: FSM first, then commands so they only affect the following cycle.
  always_comb begin
    state_d       = state_q;
    run_d         = run_q;
    single_d      = single_q;
    period_d      = period_q;
    recv_shadow_d = recv_shadow_q;
    recv_count_d  = recv_count_q;
    shot_count_d  = shot_count_q;
    overrun_d     = overrun_q;
    timeout_d     = timeout_q;
    led_d         = led_q;
    cnt_d         = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
    fire_due      = (cnt_q >= period_q - 32'd1);
    in_shot       = (state_q == S_ACK) || (state_q == S_CAPTURE) || (state_q == S_DRAIN);

    case (state_q)
      S_IDLE: begin
        if (run_q || single_q) state_d = S_FIRE;
      end
      S_FIRE: begin
        state_d = S_ACK;
      end
      S_ACK: begin
        if (cap.i_working) begin
          state_d = S_CAPTURE;
        end else if (cnt_q >= ACK_TIMEOUT_W) begin
          timeout_d = 1'b1;
          run_d     = 1'b0;
          single_d  = 1'b0;
          state_d   = S_IDLE;
        end
      end
      S_CAPTURE: begin
        if (!cap.i_working) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (cap.i_rd_empty) begin
          if (run_q && !single_q) begin
            state_d = S_WAIT;
          end else begin
            state_d  = S_IDLE;
            single_d = 1'b0;
          end
        end
      end
      S_WAIT: begin
        if (!run_q) state_d = S_IDLE;
        else if (fire_due) state_d = S_FIRE;
      end
      default: state_d = S_IDLE;
    endcase

    if (in_shot && !single_q && fire_due) overrun_d = 1'b1;

    if (state_q == S_IDLE || state_q == S_WAIT) recv_count_d = recv_shadow_q;

    if (state_d == S_FIRE) begin
      cnt_d        = '0;
      shot_count_d = shot_count_q + 16'd1;
    end

    if (i_cmd_come) begin
      case (i_cmd)
        CMD_SET_RECV:   recv_shadow_d = (i_cmd_param[15:0] < MIN_RECV_W) ? MIN_RECV_W : i_cmd_param[15:0];
        CMD_SET_PERIOD: period_d = (i_cmd_param < MIN_PERIOD_W) ? MIN_PERIOD_W : i_cmd_param;
        CMD_START:      if (state_q == S_IDLE) run_d = 1'b1;
        CMD_STOP:       run_d = 1'b0;
        CMD_SINGLE:     if (state_q == S_IDLE) single_d = 1'b1;
        CMD_LED:        led_d = i_cmd_param[3:0];
        CMD_CLEAR: begin
          overrun_d    = 1'b0;
          timeout_d    = 1'b0;
          shot_count_d = '0;
        end
        default: ;
      endcase
    end

    st_d   = (state_d == S_FIRE);
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; reset drops the strobe immediately.
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= S_IDLE;
      run_q         <= 1'b0;
      single_q      <= 1'b0;
      period_q      <= DEF_PERIOD_W;
      cnt_q         <= '0;
      recv_shadow_q <= DEF_RECV_W;
      recv_count_q  <= DEF_RECV_W;
      shot_count_q  <= '0;
      overrun_q     <= 1'b0;
      timeout_q     <= 1'b0;
      led_q         <= '0;
      st_q          <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      run_q         <= run_d;
      single_q      <= single_d;
      period_q      <= period_d;
      cnt_q         <= cnt_d;
      recv_shadow_q <= recv_shadow_d;
      recv_count_q  <= recv_count_d;
      shot_count_q  <= shot_count_d;
      overrun_q     <= overrun_d;
      timeout_q     <= timeout_d;
      led_q         <= led_d;
      st_q          <= st_d;
      busy_q        <= busy_d;
    end
  end

  assign cap.o_st         = st_q;
  assign cap.o_recv_count = recv_count_q;
  assign o_busy           = busy_q;
  assign o_shot_count     = shot_count_q;
  assign o_overrun        = overrun_q;
  assign o_timeout        = timeout_q;
  assign o_led            = led_q;

endmodule

// File: tb/tb_acq_scheduler.sv
// Self-checking bench for acq_scheduler: command table, shot scoreboard and
// hand-written sequences for period, overrun, timeout, wrap and reset corners.
module tb_acq_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_come;
  logic [7:0]  cmd;
  logic [31:0] cmd_param;
  logic        busy;
  logic [15:0] shot_count;
  logic        overrun;
  logic        timeout;
  logic [3:0]  led;

  acq_scheduler_if ifc ();

  acq_scheduler dut (
    .i_clk_sys    (clk),
    .i_rst_n      (rst_n),
    .i_cmd_come   (cmd_come),
    .i_cmd        (cmd),
    .i_cmd_param  (cmd_param),
    .cap          (ifc),
    .o_busy       (busy),
    .o_shot_count (shot_count),
    .o_overrun    (overrun),
    .o_timeout    (timeout),
    .o_led        (led)
  );

  // 100 MHz system clock
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [15:0] shots;
    logic [15:0] recv;
  } shot_t;

  typedef struct {
    string       name;
    logic [7:0]  code;
    logic [31:0] param;
    logic [3:0]  exp_led;
    logic [15:0] exp_recv;
  } vec_t;

  shot_t       exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          st_seen = 0;
  int          last_st_cyc = 0;
  bit          model_run = 1'b0;
  bit          wm_enable = 1'b1;
  int          wm_w = 20;
  int          wm_d = 3;
  int          model_period = 100000;
  logic [15:0] model_recv = 16'd10000;
  logic [15:0] model_shots = 16'd0;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, actual, expected, cyc);
  endtask

  task automatic apply_stimulus(input logic [7:0] code, input logic [31:0] param, output int c);
    @(negedge clk);
    cmd_come  = 1'b1;
    cmd       = code;
    cmd_param = param;
    c         = cyc;
    @(negedge clk);
    cmd_come  = 1'b0;
    cmd       = 8'h00;
    cmd_param = 32'h0;
  endtask

  task automatic wait_shots(input int target, input int budget);
    for (int i = 0; i < budget && st_seen < target; i++) @(negedge clk);
    check_output("shot_arrival", 32'(st_seen >= target), 32'd1);
  endtask

  task automatic wait_queue_empty(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    check_output("expected_st_arrived", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy !== 1'b0; i++) @(negedge clk);
    check_output("return_to_idle", 32'(busy), 32'd0);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_st"}, 32'(ifc.o_st), 32'd0);
    check_output({tag, "_busy"}, 32'(busy), 32'd0);
    check_output({tag, "_shot_count"}, 32'(shot_count), 32'd0);
    check_output({tag, "_overrun"}, 32'(overrun), 32'd0);
    check_output({tag, "_timeout"}, 32'(timeout), 32'd0);
    check_output({tag, "_led"}, 32'(led), 32'd0);
    check_output({tag, "_recv_count"}, 32'(ifc.o_recv_count), 32'd10000);
  endtask

  // Capture wrapper model: working 3 cycles after the strobe, FIFO drains wm_d cycles after capture.
  initial begin : wrapper_model
    int cnt;
    bit active;
    cnt            = 0;
    active         = 1'b0;
    ifc.i_working  = 1'b0;
    ifc.i_rd_empty = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active         = 1'b0;
        ifc.i_working  = 1'b0;
        ifc.i_rd_empty = 1'b1;
      end else if (active) begin
        cnt++;
        if (cnt == 3) begin
          ifc.i_working  = 1'b1;
          ifc.i_rd_empty = 1'b0;
        end
        if (cnt == 3 + wm_w) ifc.i_working = 1'b0;
        if (cnt == 3 + wm_w + wm_d) begin
          ifc.i_rd_empty = 1'b1;
          active         = 1'b0;
        end
      end else if (ifc.o_st === 1'b1 && wm_enable) begin
        active = 1'b1;
        cnt    = 0;
      end
    end
  end

  // Strobe monitor: pops the scoreboard and predicts the next continuous shot.
  initial begin : st_monitor
    shot_t e;
    int nxt;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (ifc.o_st === 1'b1) begin
        st_seen++;
        last_st_cyc = cyc;
        check_output("st_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          model_shots = e.shots;
          check_output("st_cycle", 32'(cyc), 32'(e.cyc));
          check_output("st_shot_count", 32'(shot_count), 32'(e.shots));
          check_output("st_recv_count", 32'(ifc.o_recv_count), 32'(e.recv));
          if (model_run && wm_enable) begin
            nxt = cyc + model_period;
            if (cyc + 5 + wm_w + wm_d > nxt) nxt = cyc + 5 + wm_w + wm_d;
            exp_q.push_back('{nxt, e.shots + 16'd1, model_recv});
          end
        end
      end
    end
  end

  // Hard stop if something hangs.
  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin : main_test
    vec_t vecs[10];
    int c;
    int t;

    vecs[0] = '{"led_5",        8'h06, 32'h0000_0005, 4'h5, 16'd10000};
    vecs[1] = '{"led_low_nib",  8'h06, 32'hFFFF_FFFA, 4'hA, 16'd10000};
    vecs[2] = '{"recv_clamp5",  8'h01, 32'd5,         4'hA, 16'd16};
    vecs[3] = '{"recv_min",     8'h01, 32'd16,        4'hA, 16'd16};
    vecs[4] = '{"recv_17",      8'h01, 32'd17,        4'hA, 16'd17};
    vecs[5] = '{"recv_lowhalf", 8'h01, 32'hABCD_0123, 4'hA, 16'h0123};
    vecs[6] = '{"unknown_00",   8'h00, 32'h0000_0007, 4'hA, 16'h0123};
    vecs[7] = '{"unknown_09",   8'h09, 32'h0000_000F, 4'hA, 16'h0123};
    vecs[8] = '{"recv_restore", 8'h01, 32'd10000,     4'hA, 16'd10000};
    vecs[9] = '{"led_0",        8'h06, 32'h0000_0000, 4'h0, 16'd10000};

    rst_n     = 1'b0;
    cmd_come  = 1'b0;
    cmd       = 8'h00;
    cmd_param = 32'h0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      apply_stimulus(vecs[i].code, vecs[i].param, c);
      @(negedge clk);
      check_output({"tbl_led_", vecs[i].name}, 32'(led), 32'(vecs[i].exp_led));
      check_output({"tbl_recv_", vecs[i].name}, 32'(ifc.o_recv_count), 32'(vecs[i].exp_recv));
      check_output({"tbl_busy_", vecs[i].name}, 32'(busy), 32'd0);
    end
    model_recv = 16'd10000;

    // Single shot with defaults
    wm_enable = 1'b1; wm_w = 20; wm_d = 3;
    apply_stimulus(8'h05, 32'h0, c);
    exp_q.push_back('{c + 2, model_shots + 16'd1, model_recv});
    wait_queue_empty(20);
    check_output("single_busy", 32'(busy), 32'd1);
    wait_idle(200);
    check_output("single_overrun", 32'(overrun), 32'd0);
    check_output("single_shot_count", 32'(shot_count), 32'd1);

    // Continuous shots, capture well inside the period
    model_period = 300; wm_w = 100; wm_d = 20;
    apply_stimulus(8'h02, 32'd300, c);
    apply_stimulus(8'h03, 32'h0, c);
    model_run = 1'b1;
    exp_q.push_back('{c + 2, model_shots + 16'd1, model_recv});
    wait_shots(st_seen + 3, 1200);
    repeat (10) @(negedge clk);
    apply_stimulus(8'h01, 32'd5, c);
    model_recv = 16'd16;
    if (exp_q.size() != 0) exp_q[exp_q.size() - 1].recv = 16'd16;
    @(negedge clk);
    check_output("recv_held_in_capture", 32'(ifc.o_recv_count), 32'd10000);
    wait_shots(st_seen + 1, 400);
    check_output("steady_overrun", 32'(overrun), 32'd0);
    repeat (10) @(negedge clk);
    apply_stimulus(8'h04, 32'h0, c);
    model_run = 1'b0;
    exp_q.delete();
    check_output("stop_shot_completes", 32'(busy), 32'd1);
    wait_idle(300);
    check_output("stop_shot_count", 32'(shot_count), 32'(model_shots));
    repeat (400) @(negedge clk);
    check_output("stop_no_pending", 32'(exp_q.size()), 32'd0);
    apply_stimulus(8'h07, 32'h0, c);
    check_output("clear_shot_count", 32'(shot_count), 32'd0);
    model_shots = 16'd0;

    // Overrun: period clamps to 64, capture takes longer
    model_period = 64; wm_w = 100; wm_d = 5;
    apply_stimulus(8'h02, 32'd20, c);
    apply_stimulus(8'h03, 32'h0, c);
    model_run = 1'b1;
    exp_q.push_back('{c + 2, model_shots + 16'd1, model_recv});
    wait_shots(st_seen + 1, 20);
    t = last_st_cyc;
    wait_until(t + 63);
    check_output("overrun_before_edge", 32'(overrun), 32'd0);
    wait_until(t + 64);
    check_output("overrun_at_edge", 32'(overrun), 32'd1);
    wait_shots(st_seen + 2, 400);
    repeat (10) @(negedge clk);
    apply_stimulus(8'h04, 32'h0, c);
    model_run = 1'b0;
    exp_q.delete();
    wait_idle(300);
    check_output("overrun_sticky", 32'(overrun), 32'd1);
    apply_stimulus(8'h07, 32'h0, c);
    check_output("clear_overrun", 32'(overrun), 32'd0);
    model_shots = 16'd0;

    // Acknowledge timeout in continuous mode clears run
    wm_enable = 1'b0;
    apply_stimulus(8'h03, 32'h0, c);
    model_run = 1'b1;
    exp_q.push_back('{c + 2, model_shots + 16'd1, model_recv});
    wait_shots(st_seen + 1, 20);
    t = last_st_cyc;
    wait_until(t + 16);
    check_output("timeout_before", 32'(timeout), 32'd0);
    check_output("timeout_busy_before", 32'(busy), 32'd1);
    wait_until(t + 17);
    check_output("timeout_after", 32'(timeout), 32'd1);
    check_output("timeout_busy_after", 32'(busy), 32'd0);
    model_run = 1'b0;
    repeat (100) @(negedge clk);
    check_output("timeout_run_cleared", 32'(busy), 32'd0);
    apply_stimulus(8'h07, 32'h0, c);
    check_output("clear_timeout", 32'(timeout), 32'd0);
    model_shots = 16'd0;

    // Shot counter wrap
    @(negedge clk);
    force dut.shot_count_q = 16'hFFFF;
    repeat (2) @(negedge clk);
    release dut.shot_count_q;
    @(negedge clk);
    check_output("forced_shot_count", 32'(shot_count), 32'h0000_FFFF);
    model_shots = 16'hFFFF;
    wm_enable = 1'b1; wm_w = 5; wm_d = 2;
    apply_stimulus(8'h05, 32'h0, c);
    exp_q.push_back('{c + 2, model_shots + 16'd1, model_recv});
    wait_queue_empty(20);
    wait_idle(100);
    check_output("wrap_shot_count", 32'(shot_count), 32'd0);

    // Reset asserted during ACK
    apply_stimulus(8'h06, 32'h9, c);
    check_output("led_before_reset", 32'(led), 32'd9);
    wm_enable = 1'b0;
    apply_stimulus(8'h05, 32'h0, c);
    exp_q.push_back('{c + 2, model_shots + 16'd1, model_recv});
    wait_queue_empty(20);
    repeat (2) @(negedge clk);
    check_output("busy_in_ack", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("ack_reset");
    model_recv  = 16'd10000;
    model_shots = 16'd0;
    @(negedge clk);
    rst_n = 1'b1;

    // Reset during the strobe cycle drops o_st at once
    apply_stimulus(8'h05, 32'h0, c);
    exp_q.push_back('{c + 2, model_shots + 16'd1, model_recv});
    @(negedge clk);
    check_output("st_before_reset", 32'(ifc.o_st), 32'd1);
    rst_n = 1'b0;
    #1;
    check_output("st_async_drop", 32'(ifc.o_st), 32'd0);
    check_output("busy_async_drop", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_output("final_no_pending", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
